fp32_to_int32_conv: RTL and testbench

Pipelined converter from IEEE-754 binary32 to signed 32-bit two's-complement integer. It is the reverse of the int-to-float path, which uses leading-one detection to normalize. This block denormalizes: a right shift by the unbiased exponent, then rounding, saturation and negation. It sits in the FPU convert unit behind a valid/ready handshake on both sides and sustains one result per clock.

---
 rtl/fp32_to_int32_conv.sv | 220 ++++++++++++++++++++++
 tb/tb_fp32_to_int32_conv.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_conv.sv
// fp32_to_int32_conv: IEEE-754 binary32 to signed 32-bit integer converter.
//
// Two register stages behind a valid/ready handshake on both sides, one result per clock.
//   Stage 1 decodes the operand into its sign, unbiased exponent, significand and class.
//   Stage 2 holds the rounded, range-checked and sign-applied result and its flags.
//
// Ports:
//   i_clk      clock, all state on the rising edge
//   i_rst      synchronous reset, active-high; drops in-flight operands
//   i_valid    upstream operand valid
//   o_ready    block can accept an operand this cycle (combinational from i_ready)
//   i_data     binary32 operand {sign, exp, man}
//   i_rm       rounding mode: 0 = round-to-nearest-even, 1 = round-toward-zero
//   o_valid    result valid
//   i_ready    downstream accepts the result
//   o_data     signed integer result
//   o_invalid  NaN, infinity or out-of-range operand; result saturated
//   o_inexact  a nonzero fraction was discarded (never set together with o_invalid)
module fp32_to_int32_conv #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned INT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_data,
  input  logic                   i_rm,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [INT_W-1:0]       o_data,
  output logic                   o_invalid,
  output logic                   o_inexact
);

  localparam int unsigned SigW = MAN_W + 1;
  // Unbiased exponent needs one extra bit of range plus a sign bit.
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned ShW  = $clog2(INT_W);
  localparam int          Bias = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] ExpBias   = EW'(Bias);
  localparam logic signed [EW-1:0] ExpSub    = EW'(1 - Bias);
  localparam logic signed [EW-1:0] ExpMan    = EW'(MAN_W);
  localparam logic signed [EW-1:0] ExpOvf    = EW'(INT_W);
  localparam logic signed [EW-1:0] ExpNegOne = '1;

  localparam logic [INT_W-1:0] IntMax = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] IntMin = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   LimPos = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   LimNeg = {2'b01, {(INT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Handshake: each stage advances when its successor is empty or draining.
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic adv1;
  logic adv2;

  assign adv2    = ~s2_valid_q | i_ready;
  assign adv1    = ~s1_valid_q | adv2;
  assign o_ready = adv1;

  // ---------------------------------------------------------------------------
  // Stage 1 decode
  // ---------------------------------------------------------------------------
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W-1:0]       in_man;
  logic                   in_nan;
  logic                   in_inf;
  logic signed [EW-1:0]   in_exp_unb;
  logic [SigW-1:0]        in_sig;

  assign in_sign = i_data[EXP_W+MAN_W];
  assign in_exp  = i_data[EXP_W+MAN_W-1:MAN_W];
  assign in_man  = i_data[MAN_W-1:0];
  assign in_nan  = (in_exp == '1) && (in_man != '0);
  assign in_inf  = (in_exp == '1) && (in_man == '0);
  // Zeros and subnormals share the minimum exponent with a clear hidden bit.
  assign in_sig  = {(in_exp != '0), in_man};

  always_comb begin
    if (in_exp == '0) begin
      in_exp_unb = ExpSub;
    end else begin
      in_exp_unb = $signed({2'b00, in_exp}) - ExpBias;
    end
  end

  logic                 s1_sign_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [SigW-1:0]      s1_sig_q;
  logic                 s1_nan_q;
  logic                 s1_inf_q;
  logic                 s1_rm_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_rm_q    <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= in_exp_unb;
        s1_sig_q  <= in_sig;
        s1_nan_q  <= in_nan;
        s1_inf_q  <= in_inf;
        s1_rm_q   <= i_rm;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 denormalize: integer part plus guard and sticky bits
  // ---------------------------------------------------------------------------
  logic [2*SigW-1:0] wide;
  logic [EW-1:0]     shr;
  logic [ShW-1:0]    shl;
  logic [INT_W-1:0]  int_part;
  logic              guard;
  logic              sticky;

  always_comb begin
    wide     = '0;
    shr      = '0;
    shl      = '0;
    int_part = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (s1_exp_q[EW-1]) begin
      // |x| < 1: only e = -1 can place the hidden bit at the half position.
      if (s1_exp_q == ExpNegOne) begin
        guard  = s1_sig_q[SigW-1];
        sticky = |s1_sig_q[SigW-2:0];
      end else begin
        sticky = |s1_sig_q;
      end
    end else if (s1_exp_q <= ExpMan) begin
      // Shift the significand into a double-width window; the low half holds
      // the discarded fraction with the guard bit at its top.
      shr      = EW'(ExpMan - s1_exp_q);
      wide     = {s1_sig_q, {SigW{1'b0}}} >> shr;
      int_part = INT_W'(wide[2*SigW-1:SigW]);
      guard    = wide[SigW-1];
      sticky   = |wide[SigW-2:0];
    end else begin
      // Exact left shift; exponents of INT_W and beyond are flagged below and
      // the wrapped shift amount is then irrelevant.
      shl      = ShW'(s1_exp_q - ExpMan);
      int_part = INT_W'(s1_sig_q) << shl;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 round, range-check, saturate and apply sign
  // ---------------------------------------------------------------------------
  logic             round_up;
  logic [INT_W:0]   rounded;
  logic             exp_ovf;
  logic             range_ovf;
  logic [INT_W-1:0] res_data;
  logic             res_invalid;
  logic             res_inexact;

  always_comb begin
    round_up    = ~s1_rm_q & guard & (sticky | int_part[0]);
    rounded     = {1'b0, int_part} + {{INT_W{1'b0}}, round_up};
    exp_ovf     = (s1_exp_q >= ExpOvf);
    // The negative range reaches one further than the positive range.
    range_ovf   = s1_sign_q ? (rounded > LimNeg) : (rounded > LimPos);
    res_data    = '0;
    res_invalid = 1'b0;
    res_inexact = 1'b0;
    if (s1_nan_q) begin
      res_data    = IntMax;
      res_invalid = 1'b1;
    end else if (s1_inf_q || exp_ovf || range_ovf) begin
      res_data    = s1_sign_q ? IntMin : IntMax;
      res_invalid = 1'b1;
    end else begin
      res_data    = s1_sign_q ? ('0 - rounded[INT_W-1:0]) : rounded[INT_W-1:0];
      res_inexact = guard | sticky;
    end
  end

  logic [INT_W-1:0] s2_data_q;
  logic             s2_invalid_q;
  logic             s2_inexact_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_invalid_q <= 1'b0;
      s2_inexact_q <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q    <= res_data;
        s2_invalid_q <= res_invalid;
        s2_inexact_q <= res_inexact;
      end
    end
  end

  assign o_valid   = s2_valid_q;
  assign o_data    = s2_data_q;
  assign o_invalid = s2_invalid_q;
  assign o_inexact = s2_inexact_q;

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// Self-checking bench for fp32_to_int32_conv: directed vectors, reset behaviour,
// backpressure streaming and full-rate latency/throughput.
module tb_fp32_to_int32_conv;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_rm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_invalid;
  logic        o_inexact;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp32_to_int32_conv dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_rm      (i_rm),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_invalid (o_invalid),
    .o_inexact (o_inexact)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scale |x| by 2^149 so every binary32 fraction bit is an integer bit,
  // then round on the exact fraction. Returns {invalid, inexact, result}.
  function automatic logic [33:0] ref_conv(input logic [31:0] d, input logic rm);
    logic         sign;
    logic [7:0]   ex;
    logic [22:0]  man;
    logic [23:0]  sig;
    logic [191:0] fx;
    logic [148:0] frac;
    logic [148:0] half;
    logic [63:0]  ip;
    logic         up;
    int           e;
    sign = d[31];
    ex   = d[30:23];
    man  = d[22:0];
    if (ex == 8'hFF) begin
      if (man != 0) return {2'b10, 32'h7FFF_FFFF};
      return {2'b10, sign ? 32'h8000_0000 : 32'h7FFF_FFFF};
    end
    e = (ex == 0) ? -126 : int'(ex) - 127;
    if (e >= 32) return {2'b10, sign ? 32'h8000_0000 : 32'h7FFF_FFFF};
    sig  = {(ex != 0), man};
    fx   = 192'(sig) << (e + 126);
    frac = fx[148:0];
    ip   = 64'(fx >> 149);
    half = 149'(1) << 148;
    up   = !rm && ((frac > half) || ((frac == half) && ip[0]));
    ip   = ip + 64'(up);
    if ((!sign && ip > 64'h7FFF_FFFF) || (sign && ip > 64'h8000_0000))
      return {2'b10, sign ? 32'h8000_0000 : 32'h7FFF_FFFF};
    return {1'b0, (frac != 0), sign ? 32'(64'd0 - ip) : ip[31:0]};
  endfunction

  // One isolated operand with i_ready high; checks latency, result and flags.
  task automatic run_vec(input string tag, input logic [31:0] d, input logic rm,
                         input logic [31:0] exp_data, input logic exp_inv,
                         input logic exp_inx);
    int n;
    check({tag, " ready"}, 64'(o_ready), 64'd1);
    i_data  = d;
    i_rm    = rm;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (n = 0; n < 8 && !o_valid; n++) begin
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 64'(n), 64'd1);
    check({tag, " data"}, 64'(o_data), 64'(exp_data));
    check({tag, " invalid"}, 64'(o_invalid), 64'(exp_inv));
    check({tag, " inexact"}, 64'(o_inexact), 64'(exp_inx));
  endtask

  logic [31:0] ops [16];
  logic        rms [16];
  logic [33:0] exp_q [$];
  logic [33:0] exp_item;
  logic [31:0] held_data;
  logic        held_inv;
  logic        held_inx;
  logic        stall_prev;
  logic [31:0] r;
  int          sent;
  int          got;
  int          cyc;
  int          first_acc;
  int          first_out;
  int          last_out;

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_rm    = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o_data", 64'(o_data), 64'd0);
    check("reset o_invalid", 64'(o_invalid), 64'd0);
    check("reset o_inexact", 64'(o_inexact), 64'd0);
    check("reset o_ready", 64'(o_ready), 64'd1);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: rm 0 = RNE, 1 = RTZ.
    run_vec("rne 1.5",      32'h3FC0_0000, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
    run_vec("rne 2.5",      32'h4020_0000, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
    run_vec("rne -2.5",     32'hC020_0000, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run_vec("rtz -2.5",     32'hC020_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run_vec("rtz 0.99",     32'h3F7F_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    run_vec("rne 0.99",     32'h3F7F_FFFF, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
    run_vec("rne 0.5",      32'h3F00_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_vec("rne -0.5",     32'hBF00_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_vec("rne -0.75",    32'hBF40_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_vec("rne 1.75",     32'h3FE0_0000, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
    run_vec("rtz 1.75",     32'h3FE0_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
    run_vec("rne -2^31",    32'hCF00_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    run_vec("rne 2^31",     32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_vec("rne below -2^31", 32'hCF00_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
    run_vec("rne max pos",  32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, 1'b0, 1'b0);
    run_vec("rne max neg",  32'hCEFF_FFFF, 1'b0, 32'h8000_0080, 1'b0, 1'b0);
    run_vec("rne +inf",     32'h7F80_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_vec("rne -inf",     32'hFF80_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
    run_vec("rne +nan",     32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_vec("rne -nan",     32'hFFC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_vec("rne -0",       32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("rne subnorm",  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_vec("rtz subnorm",  32'h8040_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    run_vec("rne 2^24-1",   32'h4B7F_FFFF, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0);
    run_vec("rne 2^23+1",   32'h4B00_0001, 1'b0, 32'h0080_0001, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset with two operands in flight, downstream stalled.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h4B7F_FFFF;
    i_rm    = 1'b0;
    @(posedge clk); #1;
    i_data  = 32'h3FC0_0000;
    @(posedge clk); #1;
    check("pre-reset o_valid", 64'(o_valid), 64'd1);
    check("pre-reset o_data", 64'(o_data), 64'h00FF_FFFF);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge clk); #1;
    i_rst   = 1'b0;
    check("mid reset o_valid", 64'(o_valid), 64'd0);
    check("mid reset o_data", 64'(o_data), 64'd0);
    check("mid reset o_ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'h4020_0000;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("post reset early o_valid", 64'(o_valid), 64'd0);
    @(posedge clk); #1;
    check("post reset o_valid", 64'(o_valid), 64'd1);
    check("post reset o_data", 64'(o_data), 64'h0000_0002);
    check("post reset o_inexact", 64'(o_inexact), 64'd1);
    @(posedge clk); #1;
    check("post reset drained", 64'(o_valid), 64'd0);

    // Backpressure stream: random operands, random i_ready.
    for (int i = 0; i < 16; i++) begin
      r      = $urandom;
      ops[i] = {r[31], 8'($urandom_range(110, 162)), r[22:0]};
      rms[i] = 1'($urandom_range(0, 1));
    end
    sent       = 0;
    got        = 0;
    stall_prev = 1'b0;
    held_data  = '0;
    held_inv   = 1'b0;
    held_inx   = 1'b0;
    i_data     = ops[0];
    i_rm       = rms[0];
    i_valid    = 1'b1;
    i_ready    = 1'($urandom_range(0, 1));
    for (cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        check("bp stall valid", 64'(o_valid), 64'd1);
        check("bp stall data", 64'(o_data), 64'(held_data));
        check("bp stall flags", 64'({o_invalid, o_inexact}), 64'({held_inv, held_inx}));
      end
      if (o_valid && i_ready) begin
        check("bp queue nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_item = exp_q.pop_front();
          check("bp result", 64'({o_invalid, o_inexact, o_data}), 64'(exp_item));
        end
        got++;
      end
      stall_prev = o_valid && !i_ready;
      held_data  = o_data;
      held_inv   = o_invalid;
      held_inx   = o_inexact;
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_conv(ops[sent], rms[sent]));
        sent++;
      end
      @(posedge clk); #1;
      if (sent < 16) begin
        i_data  = ops[sent];
        i_rm    = rms[sent];
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      i_ready = 1'($urandom_range(0, 1));
    end
    check("bp results received", 64'(got), 64'd16);
    check("bp nothing left", 64'(exp_q.size()), 64'd0);
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp no extra output", 64'(o_valid), 64'd0);

    // Full rate: i_ready high throughout.
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      r      = $urandom;
      ops[i] = {r[31], 8'($urandom_range(100, 160)), r[22:0]};
      rms[i] = 1'($urandom_range(0, 1));
    end
    sent      = 0;
    got       = 0;
    first_acc = -1;
    first_out = -1;
    last_out  = -1;
    i_data    = ops[0];
    i_rm      = rms[0];
    i_valid   = 1'b1;
    for (cyc = 0; cyc < 100 && got < 16; cyc++) begin
      @(negedge clk);
      if (o_valid) begin
        if (exp_q.size() > 0) exp_item = exp_q.pop_front();
        else exp_item = '1;
        check("flow result", 64'({o_invalid, o_inexact, o_data}), 64'(exp_item));
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_conv(ops[sent], rms[sent]));
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      @(posedge clk); #1;
      if (sent < 16) begin
        i_data  = ops[sent];
        i_rm    = rms[sent];
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
    end
    check("flow results received", 64'(got), 64'd16);
    check("flow first result cycle", 64'(first_out), 64'(first_acc + 2));
    check("flow consecutive results", 64'(last_out - first_out), 64'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
